pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 24 ++
 rtl/pc_sequencer.sv | 112 +++++++++++
 tb/tb_pc_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch PC sequencer: FSM state encoding,
// the default reset PC, and small arithmetic helpers.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HALT     = 2'd3
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    // Sequential PC step; wraps modulo 2^32 with no overflow indication.
    function automatic logic [31:0] pc_add4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // Redirect counter step that sticks at all-ones.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: boots to RESET_PC, steps by 4 on accepted fetches,
// redirects on taken branches (one flush cycle), and halts with a sticky
// trap on a misaligned branch target when ALIGN_CHECK is set.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall_i,
    input  logic        Branch_Flag_i,
    input  logic [31:0] Branch_Target_i,
    input  logic        Imem_Ready_i,
    output logic        Imem_Req_o,
    output logic [31:0] PC_o,
    output logic [31:0] PC_Plus4_o,
    output logic        Flush_o,
    output logic        Trap_o,
    output logic [7:0]  Redirect_Cnt_o
);

    pc_state_e   r_state;
    pc_state_e   w_next_state;
    logic [31:0] r_pc;
    logic [31:0] w_next_pc;
    logic [31:0] w_pc_plus4;
    logic [7:0]  r_redirect_cnt;
    logic        w_cnt_inc;
    logic        w_misaligned;
    logic        r_imem_req;
    logic        r_flush;
    logic        r_trap;

    assign w_pc_plus4   = pc_add4(r_pc);
    assign w_misaligned = ALIGN_CHECK && (Branch_Target_i[1:0] != 2'b00);

    // Next-state, next-PC and counter-enable decode; branch has priority in FETCH.
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_cnt_inc    = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                if (Branch_Flag_i) begin
                    if (w_misaligned) begin
                        w_next_state = ST_HALT;
                    end else begin
                        // Aligned targets already have zero low bits; the
                        // non-checking variant force-aligns here.
                        w_next_state = ST_REDIRECT;
                        w_next_pc    = {Branch_Target_i[31:2], 2'b00};
                        w_cnt_inc    = 1'b1;
                    end
                end else if (Imem_Ready_i && !Stall_i) begin
                    w_next_pc = w_pc_plus4;
                end else begin
                    w_next_pc = r_pc;
                end
            end
            ST_REDIRECT: begin
                w_next_state = ST_FETCH;
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
            default: begin
                w_next_state = ST_BOOT;
            end
        endcase
    end

    // State, PC and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_BOOT;
            r_pc           <= RESET_PC;
            r_redirect_cnt <= 8'h00;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            if (w_cnt_inc) begin
                r_redirect_cnt <= sat_inc8(r_redirect_cnt);
            end
        end
    end

    // Registered status outputs, decoded from the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_imem_req <= 1'b0;
            r_flush    <= 1'b0;
            r_trap     <= 1'b0;
        end else begin
            r_imem_req <= (w_next_state == ST_FETCH);
            r_flush    <= (w_next_state == ST_REDIRECT);
            r_trap     <= (w_next_state == ST_HALT);
        end
    end

    assign PC_o           = r_pc;
    assign PC_Plus4_o     = w_pc_plus4;
    assign Imem_Req_o     = r_imem_req;
    assign Flush_o        = r_flush;
    assign Trap_o         = r_trap;
    assign Redirect_Cnt_o = r_redirect_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: one instance with alignment checking,
// one with force-alignment, both driven by the same stimulus.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch;
    logic [31:0] target;
    logic        ready;

    logic        req_a, flush_a, trap_a;
    logic [31:0] pc_a, pc4_a;
    logic [7:0]  cnt_a;

    logic        req_b, flush_b, trap_b;
    logic [31:0] pc_b, pc4_b;
    logic [7:0]  cnt_b;

    int n_checks;
    int n_err;

    pc_sequencer #(.RESET_PC(32'h0040_0000), .ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .reset(reset), .Stall_i(stall), .Branch_Flag_i(branch),
        .Branch_Target_i(target), .Imem_Ready_i(ready), .Imem_Req_o(req_a),
        .PC_o(pc_a), .PC_Plus4_o(pc4_a), .Flush_o(flush_a), .Trap_o(trap_a),
        .Redirect_Cnt_o(cnt_a)
    );

    pc_sequencer #(.RESET_PC(32'h0040_0000), .ALIGN_CHECK(1'b0)) dut_noalign (
        .clk(clk), .reset(reset), .Stall_i(stall), .Branch_Flag_i(branch),
        .Branch_Target_i(target), .Imem_Ready_i(ready), .Imem_Req_o(req_b),
        .PC_o(pc_b), .PC_Plus4_o(pc4_b), .Flush_o(flush_b), .Trap_o(trap_b),
        .Redirect_Cnt_o(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        reset    = 1'b0;
        stall    = 1'b0;
        branch   = 1'b0;
        target   = 32'h0;
        ready    = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_pc",    pc_a, 32'h0040_0000);
        chk("rst_req",   32'(req_a), 32'd0);
        chk("rst_flush", 32'(flush_a), 32'd0);
        chk("rst_trap",  32'(trap_a), 32'd0);
        chk("rst_cnt",   32'(cnt_a), 32'd0);

        // Release; BOOT keeps the request low until the first edge
        reset = 1'b1;
        #1;
        chk("boot_req", 32'(req_a), 32'd0);
        @(negedge clk);
        chk("fetch0_pc",  pc_a, 32'h0040_0000);
        chk("fetch0_req", 32'(req_a), 32'd1);
        chk("fetch0_pc4", pc4_a, 32'h0040_0004);
        @(negedge clk);
        chk("fetch1_pc", pc_a, 32'h0040_0004);
        @(negedge clk);
        chk("fetch2_pc", pc_a, 32'h0040_0008);

        // Stall three cycles at 0x00400008
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_pc",  pc_a, 32'h0040_0008);
            chk("stall_req", 32'(req_a), 32'd1);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("resume_pc", pc_a, 32'h0040_000C);

        // Taken branch wins over a stall
        branch = 1'b1;
        target = 32'h0040_0100;
        stall  = 1'b1;
        @(negedge clk);
        chk("br_pc",    pc_a, 32'h0040_0100);
        chk("br_flush", 32'(flush_a), 32'd1);
        chk("br_req",   32'(req_a), 32'd0);
        chk("br_cnt",   32'(cnt_a), 32'd1);
        // A branch during REDIRECT is ignored
        stall  = 1'b0;
        target = 32'h0050_0000;
        @(negedge clk);
        branch = 1'b0;
        chk("br_after_pc",    pc_a, 32'h0040_0100);
        chk("br_after_flush", 32'(flush_a), 32'd0);
        chk("br_after_req",   32'(req_a), 32'd1);
        chk("br_after_cnt",   32'(cnt_a), 32'd1);
        @(negedge clk);
        chk("br_next_pc", pc_a, 32'h0040_0104);

        // Wrap-around at the top of the address space
        branch = 1'b1;
        target = 32'hFFFF_FFFC;
        @(negedge clk);
        branch = 1'b0;
        chk("wrap_tgt_pc", pc_a, 32'hFFFF_FFFC);
        chk("wrap_cnt",    32'(cnt_a), 32'd2);
        @(negedge clk);
        chk("wrap_fetch_pc", pc_a, 32'hFFFF_FFFC);
        chk("wrap_pc4",      pc4_a, 32'h0000_0000);
        @(negedge clk);
        chk("wrap_pc", pc_a, 32'h0000_0000);

        // Misaligned target: trap on the checking instance, align on the other
        branch = 1'b1;
        target = 32'h0040_0102;
        @(negedge clk);
        chk("mis_trap",  32'(trap_a), 32'd1);
        chk("mis_pc",    pc_a, 32'h0000_0000);
        chk("mis_req",   32'(req_a), 32'd0);
        chk("mis_flush", 32'(flush_a), 32'd0);
        chk("mis_cnt",   32'(cnt_a), 32'd2);
        chk("noal_pc",   pc_b, 32'h0040_0100);
        chk("noal_flush", 32'(flush_b), 32'd1);
        chk("noal_cnt",  32'(cnt_b), 32'd3);
        target = 32'h0040_0200;
        @(negedge clk);
        branch = 1'b0;
        chk("halt_ign_pc",   pc_a, 32'h0000_0000);
        chk("halt_ign_trap", 32'(trap_a), 32'd1);
        chk("halt_ign_cnt",  32'(cnt_a), 32'd2);
        @(negedge clk);
        chk("halt_sticky", 32'(trap_a), 32'd1);
        chk("halt_req",    32'(req_a), 32'd0);

        // Reset clears the trap
        reset = 1'b0;
        #1;
        chk("halt_rst_trap", 32'(trap_a), 32'd0);
        chk("halt_rst_pc",   pc_a, 32'h0040_0000);
        chk("halt_rst_cnt",  32'(cnt_a), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reboot_req", 32'(req_a), 32'd1);
        chk("reboot_pc",  pc_a, 32'h0040_0000);

        // 300 redirects saturate the counter
        for (int i = 0; i < 300; i++) begin
            branch = 1'b1;
            target = 32'h0040_0000 + 32'(i) * 32'd16;
            @(negedge clk);
            branch = 1'b0;
            @(negedge clk);
        end
        chk("sat_cnt", 32'(cnt_a), 32'hFF);
        chk("sat_pc",  pc_a, 32'h0040_0000 + 32'd299 * 32'd16);

        // Asynchronous reset in the middle of REDIRECT
        branch = 1'b1;
        target = 32'h0040_0300;
        @(negedge clk);
        branch = 1'b0;
        chk("mid_flush", 32'(flush_a), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_pc",    pc_a, 32'h0040_0000);
        chk("async_flush", 32'(flush_a), 32'd0);
        chk("async_req",   32'(req_a), 32'd0);
        chk("async_trap",  32'(trap_a), 32'd0);
        chk("async_cnt",   32'(cnt_a), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
